// File: rtl/startup_display_seq.sv
// startup_display_seq: steps a pattern ROM address through NUM_PAT patterns with a
// fixed dwell per pattern, repeats LOOPS times (0 = forever), then blanks and reports done.
`default_nettype none

module startup_display_seq #(
  parameter int NUM_PAT     = 10,
  parameter int ADR_WIDTH   = 4,
  parameter int DWELL       = 3000,
  parameter int DWELL_WIDTH = 16,
  parameter int LOOPS       = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 run_i,
  input  logic                 abort_i,
  output logic [ADR_WIDTH-1:0] pat_adr_o,
  output logic                 load_pat_o,
  output logic                 nxt_adr_o,
  output logic                 clear_o,
  output logic                 disp_o,
  output logic                 busy_o,
  output logic                 done_o
);

  localparam logic [ADR_WIDTH-1:0]   ADR_LAST   = ADR_WIDTH'(NUM_PAT - 1);
  localparam logic [DWELL_WIDTH-1:0] DWELL_LAST = DWELL_WIDTH'(DWELL - 1);
  localparam logic [7:0]             LOOP_LAST  = (LOOPS == 0) ? 8'd0 : 8'(LOOPS - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SKIP = 3'd1,
    S_LOAD = 3'd2,
    S_WAIT = 3'd3,
    S_NEXT = 3'd4,
    S_END  = 3'd5
  } state_t;

  state_t                 state_q, state_d;
  logic [ADR_WIDTH-1:0]   adr_q, adr_d;
  logic [DWELL_WIDTH-1:0] timer_q, timer_d;
  logic [7:0]             loop_q, loop_d;
  logic                   load_q, load_d;
  logic                   nxt_q, nxt_d;
  logic                   clear_q, clear_d;
  logic                   disp_q, disp_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   wrap;

  always_comb begin
    state_d = state_q;
    wrap    = 1'b0;
    case (state_q)
      S_IDLE: if (run_i) state_d = S_SKIP;
      S_SKIP: state_d = S_LOAD;
      S_LOAD: state_d = S_WAIT;
      S_WAIT: begin
        if (timer_q == DWELL_LAST) begin
          if (adr_q != ADR_LAST) begin
            state_d = S_NEXT;
          end else if (LOOPS == 0 || loop_q < LOOP_LAST) begin
            state_d = S_NEXT;
            wrap    = 1'b1;
          end else begin
            state_d = S_END;
          end
        end
      end
      S_NEXT: state_d = S_SKIP;
      S_END:  state_d = S_END;
      default: state_d = S_IDLE;
    endcase

    // Abort wins over every transition out of a busy state.
    if (abort_i && state_q != S_IDLE && state_q != S_END) begin
      state_d = S_END;
      wrap    = 1'b0;
    end

    timer_d = '0;
    if (state_q == S_WAIT && state_d == S_WAIT) begin
      timer_d = (timer_q == '1) ? timer_q : timer_q + 1'b1;
    end

    loop_d = loop_q;
    if (state_q == S_IDLE) begin
      loop_d = '0;
    end else if (wrap && LOOPS != 0) begin
      loop_d = loop_q + 8'd1;
    end

    adr_d = adr_q;
    if (state_d == S_IDLE) begin
      adr_d = '0;
    end else if (state_d == S_NEXT) begin
      adr_d = (adr_q == ADR_LAST) ? '0 : adr_q + 1'b1;
    end

    // Outputs decoded from the next state so they line up with the state register.
    load_d  = 1'b0;
    nxt_d   = 1'b0;
    clear_d = 1'b0;
    disp_d  = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (state_d)
      S_IDLE: clear_d = 1'b1;
      S_END: begin
        clear_d = 1'b1;
        done_d  = 1'b1;
      end
      S_LOAD: begin
        load_d = 1'b1;
        disp_d = 1'b1;
        busy_d = 1'b1;
      end
      S_NEXT: begin
        nxt_d  = 1'b1;
        disp_d = 1'b1;
        busy_d = 1'b1;
      end
      S_SKIP, S_WAIT: begin
        disp_d = 1'b1;
        busy_d = 1'b1;
      end
      default: clear_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      adr_q   <= '0;
      timer_q <= '0;
      loop_q  <= '0;
      load_q  <= 1'b0;
      nxt_q   <= 1'b0;
      clear_q <= 1'b1;
      disp_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      timer_q <= timer_d;
      loop_q  <= loop_d;
      load_q  <= load_d;
      nxt_q   <= nxt_d;
      clear_q <= clear_d;
      disp_q  <= disp_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign pat_adr_o  = adr_q;
  assign load_pat_o = load_q;
  assign nxt_adr_o  = nxt_q;
  assign clear_o    = clear_q;
  assign disp_o     = disp_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;

endmodule

`default_nettype wire

// File: tb/tb_startup_display_seq.sv
// Bench for startup_display_seq: several parameterisations driven with directed timelines.
`default_nettype none

module tb_startup_display_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Five instances: A basic, B two loops, C infinite, D single pattern, E abort/reset.
  logic       rst_a, run_a, abort_a, rst_b, run_b, rst_c, run_c, rst_d, run_d;
  logic       rst_e, run_e, abort_e;
  logic [3:0] adr_a, adr_b, adr_c, adr_d, adr_e;
  logic       ld_a, nx_a, cl_a, ds_a, bs_a, dn_a;
  logic       ld_b, nx_b, cl_b, ds_b, bs_b, dn_b;
  logic       ld_c, nx_c, cl_c, ds_c, bs_c, dn_c;
  logic       ld_d, nx_d, cl_d, ds_d, bs_d, dn_d;
  logic       ld_e, nx_e, cl_e, ds_e, bs_e, dn_e;

  startup_display_seq #(.NUM_PAT(3), .ADR_WIDTH(4), .DWELL(4), .DWELL_WIDTH(16), .LOOPS(1)) u_a (
    .clk_i(clk), .rst_i(rst_a), .run_i(run_a), .abort_i(abort_a), .pat_adr_o(adr_a),
    .load_pat_o(ld_a), .nxt_adr_o(nx_a), .clear_o(cl_a), .disp_o(ds_a), .busy_o(bs_a), .done_o(dn_a));
  startup_display_seq #(.NUM_PAT(3), .ADR_WIDTH(4), .DWELL(4), .DWELL_WIDTH(16), .LOOPS(2)) u_b (
    .clk_i(clk), .rst_i(rst_b), .run_i(run_b), .abort_i(1'b0), .pat_adr_o(adr_b),
    .load_pat_o(ld_b), .nxt_adr_o(nx_b), .clear_o(cl_b), .disp_o(ds_b), .busy_o(bs_b), .done_o(dn_b));
  startup_display_seq #(.NUM_PAT(3), .ADR_WIDTH(4), .DWELL(4), .DWELL_WIDTH(16), .LOOPS(0)) u_c (
    .clk_i(clk), .rst_i(rst_c), .run_i(run_c), .abort_i(1'b0), .pat_adr_o(adr_c),
    .load_pat_o(ld_c), .nxt_adr_o(nx_c), .clear_o(cl_c), .disp_o(ds_c), .busy_o(bs_c), .done_o(dn_c));
  startup_display_seq #(.NUM_PAT(1), .ADR_WIDTH(4), .DWELL(1), .DWELL_WIDTH(16), .LOOPS(1)) u_d (
    .clk_i(clk), .rst_i(rst_d), .run_i(run_d), .abort_i(1'b0), .pat_adr_o(adr_d),
    .load_pat_o(ld_d), .nxt_adr_o(nx_d), .clear_o(cl_d), .disp_o(ds_d), .busy_o(bs_d), .done_o(dn_d));
  startup_display_seq #(.NUM_PAT(3), .ADR_WIDTH(4), .DWELL(4), .DWELL_WIDTH(16), .LOOPS(1)) u_e (
    .clk_i(clk), .rst_i(rst_e), .run_i(run_e), .abort_i(abort_e), .pat_adr_o(adr_e),
    .load_pat_o(ld_e), .nxt_adr_o(nx_e), .clear_o(cl_e), .disp_o(ds_e), .busy_o(bs_e), .done_o(dn_e));

  typedef struct {
    logic       run;
    logic       load;
    logic       nxt;
    logic [3:0] adr;
    logic       disp;
    logic       busy;
    logic       done;
    logic       clear;
  } vec_t;

  localparam int NV = 25;
  vec_t vec [NV];

  initial begin
    int         first_done;
    int         nload;
    int         wraps;
    logic [3:0] prev;
    logic       done_seen, busy_low;
    logic [3:0] adrs [$];
    logic [3:0] exp_b [6];

    // Basic pass, NUM_PAT=3 DWELL=4 LOOPS=1, RUN held high throughout:
    // Skip 0/7/14, Load 1/8/15, Wait 2-5/9-12/16-19, Next 6/13, End from 20.
    for (int e = 0; e < NV; e++) begin
      vec[e].run   = 1'b1;
      vec[e].load  = (e == 1 || e == 8 || e == 15);
      vec[e].nxt   = (e == 6 || e == 13);
      vec[e].adr   = (e < 6) ? 4'd0 : (e < 13) ? 4'd1 : 4'd2;
      vec[e].done  = (e >= 20);
      vec[e].clear = (e >= 20);
      vec[e].disp  = (e < 20);
      vec[e].busy  = (e < 20);
    end
    exp_b = '{4'd0, 4'd1, 4'd2, 4'd0, 4'd1, 4'd2};

    {rst_a, rst_b, rst_c, rst_d, rst_e} = 5'b11111;
    {run_a, run_b, run_c, run_d, run_e, abort_a, abort_e} = 7'b0;
    #1;
    chk("reset_state_a", {ld_a, nx_a, adr_a, ds_a, bs_a, dn_a, cl_a}, {1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1});
    repeat (2) @(negedge clk);
    {rst_a, rst_b, rst_c, rst_d, rst_e} = 5'b00000;

    // A: table-driven per-edge check
    for (int e = 0; e < NV; e++) begin
      @(negedge clk);
      run_a = vec[e].run;
      @(posedge clk);
      #1;
      chk($sformatf("basic_edge%0d", e),
          {ld_a, nx_a, adr_a, ds_a, bs_a, dn_a, cl_a},
          {vec[e].load, vec[e].nxt, vec[e].adr, vec[e].disp, vec[e].busy, vec[e].done, vec[e].clear});
    end
    run_a = 1'b0;

    // B: two loops
    @(negedge clk); run_b = 1'b1;
    first_done = -1;
    for (int e = 0; e <= 50; e++) begin
      @(posedge clk); #1;
      if (e == 0) run_b = 1'b0;
      if (ld_b) adrs.push_back(adr_b);
      if (dn_b && first_done < 0) first_done = e;
    end
    chk("loop2_load_count", adrs.size(), 6);
    for (int i = 0; i < 6; i++)
      if (i < adrs.size()) chk($sformatf("loop2_adr%0d", i), adrs[i], exp_b[i]);
    chk("loop2_end_edge", first_done, 41);
    chk("loop2_end_adr", adr_b, 4'd2);

    // C: infinite; wraps 2->0 happen at edges 20+21m, i.e. 47 within edges 0..999
    @(negedge clk); run_c = 1'b1;
    wraps = 0; done_seen = 1'b0; busy_low = 1'b0; prev = 4'd0;
    for (int e = 0; e < 1000; e++) begin
      @(posedge clk); #1;
      if (e == 0) run_c = 1'b0;
      if (prev == 4'd2 && adr_c == 4'd0) wraps++;
      prev = adr_c;
      if (dn_c) done_seen = 1'b1;
      if (!bs_c) busy_low = 1'b1;
    end
    chk("inf_no_done", done_seen, 1'b0);
    chk("inf_busy_held", busy_low, 1'b0);
    chk("inf_wraps", wraps, 47);

    // D: NUM_PAT=1, DWELL=1 -> Load at 1, End at 3
    @(negedge clk); run_d = 1'b1;
    first_done = -1; nload = 0;
    for (int e = 0; e <= 8; e++) begin
      @(posedge clk); #1;
      if (ld_d) begin
        nload++;
        chk("single_load_edge", e, 1);
      end
      if (dn_d && first_done < 0) first_done = e;
    end
    chk("single_load_count", nload, 1);
    chk("single_end_edge", first_done, 3);
    chk("single_adr", adr_d, 4'd0);
    run_d = 1'b0;

    // E: abort during the second Wait (edges 9..12), raised before edge 10
    @(negedge clk); run_e = 1'b1;
    for (int e = 0; e <= 9; e++) begin
      @(posedge clk); #1;
      if (e == 0) run_e = 1'b0;
    end
    chk("abort_pre_adr", adr_e, 4'd1);
    @(negedge clk); abort_e = 1'b1;
    @(posedge clk); #1;
    chk("abort_end", {dn_e, cl_e, ds_e, bs_e, adr_e}, {1'b1, 1'b1, 1'b0, 1'b0, 4'd1});
    @(negedge clk); abort_e = 1'b0;
    nload = 0;
    for (int e = 0; e < 20; e++) begin
      @(negedge clk); run_e = ~run_e;
      @(posedge clk); #1;
      if (ld_e) nload++;
    end
    run_e = 1'b0;
    chk("abort_no_reload", nload, 0);
    chk("abort_frozen", {dn_e, adr_e}, {1'b1, 4'd1});

    // E: asynchronous reset in the middle of the second Wait
    @(negedge clk); rst_e = 1'b1;
    @(negedge clk); rst_e = 1'b0; run_e = 1'b1;
    for (int e = 0; e <= 10; e++) begin
      @(posedge clk); #1;
      if (e == 0) run_e = 1'b0;
    end
    chk("rst_pre_state", {ds_e, bs_e, adr_e}, {1'b1, 1'b1, 4'd1});
    #2 rst_e = 1'b1;
    #1;
    chk("rst_async", {cl_e, ds_e, bs_e, dn_e, adr_e}, {1'b1, 1'b0, 1'b0, 1'b0, 4'd0});
    @(negedge clk); rst_e = 1'b0;
    busy_low = 1'b1;
    for (int e = 0; e < 5; e++) begin
      @(posedge clk); #1;
      if (!(cl_e && !ds_e && !bs_e && !dn_e && !ld_e)) busy_low = 1'b0;
    end
    chk("rst_stay_idle", busy_low, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/startup_display_seq.md
# startup_display_seq

Parametrised startup display sequencer for the front-panel/LED pattern display. After RUN it steps a pattern ROM address through NUM_PAT patterns, loads each one, and holds it for a programmable dwell measured by an internal timer. It repeats the whole sequence LOOPS times, or forever, then blanks the display and reports DONE. ABORT can terminate the sequence early. It sits between the power-up controller (RUN/ABORT) and the pattern ROM/display shift logic (PAT_ADR, LOAD_PAT, CLEAR, DISP).

## Interface
- NUM_PAT, default 10: number of patterns; legal range 1..2^ADR_WIDTH.
- ADR_WIDTH, default 4: width of PAT_ADR.
- DWELL, default 3000: cycles each pattern is held in Wait; minimum 1; must fit in DWELL_WIDTH.
- DWELL_WIDTH, default 16: width of the internal dwell timer.
- LOOPS, default 1: number of passes through the sequence; 0 means repeat forever. Maximum 255.
- CLK  input  1  system clock.
- RST  input  1  reset, asynchronous and active-high.
- RUN  input  1  level; starts the sequence; sampled only in Idle.
- ABORT  input  1  level; forces End from any busy state.
- PAT_ADR  output  ADR_WIDTH  pattern ROM address (registered).
- LOAD_PAT  output  1  one-cycle pulse; latch the ROM data at PAT_ADR.
- NXT_ADR  output  1  one-cycle pulse when PAT_ADR advances.
- CLEAR  output  1  clear the display register.
- DISP  output  1  display enable.
- BUSY  output  1  sequence in progress.
- DONE  output  1  sequence finished (sticky until RST).

## Operation
- States: Idle, Skip, Load, Wait, Next, End. Encoding is free.
- Idle: if RUN is high, go to Skip; otherwise stay in Idle.
- Skip: one ROM settle cycle; go to Load.
- Load: go to Wait.
- Wait: internal timer increments each cycle. When timer == DWELL-1:
  - if PAT_ADR ≠ NUM_PAT-1, go to Next;
  - else if LOOPS = 0 or loops completed < LOOPS-1, go to Next (wrap) and increment the loop count;
  - else go to End.
- Next: PAT_ADR ← PAT_ADR+1, or 0 when it was NUM_PAT-1; go to Skip.
- End: terminal; only RST leaves it. RUN is ignored.
- ABORT high in Skip, Load, Wait or Next: go to End on the next edge. This overrides all other transitions. ABORT is ignored in Idle and End.
- Timer: cleared in every state except Wait. It saturates; no wrap is needed because Wait exits at DWELL-1.
- Loop counter: 8 bits, cleared in Idle, not used when LOOPS = 0.
- Outputs are registered and decoded from nextstate, so each output is valid in the same cycle as the state it belongs to:
  - Idle: CLEAR=1, DISP=0, BUSY=0.
  - End: CLEAR=1, DISP=0, BUSY=0, DONE=1.
  - Load: LOAD_PAT=1, DISP=1, BUSY=1.
  - Next: NXT_ADR=1, DISP=1, BUSY=1.
  - Skip and Wait: DISP=1, BUSY=1.
  - All outputs not listed for a state are 0.
- PAT_ADR is 0 in Idle. It changes on the edge that enters Next, holds in every other state, and is frozen in End.

## Timing
- Reset values (asynchronous, while RST is high): state=Idle, PAT_ADR=0, CLEAR=1, DISP=0, LOAD_PAT=0, NXT_ADR=0, BUSY=0, DONE=0, timer=0, loop counter=0.
- RST asserted mid-sequence: all values above apply immediately, with no wait for a clock edge.
- Timeline, with RUN sampled high at edge k:
  - Skip at k, Load at k+1 (PAT_ADR=0).
  - Wait occupies exactly DWELL cycles, k+2 through k+1+DWELL.
  - Next at k+2+DWELL.
- Pattern period is DWELL+3 cycles (Wait, Next, Skip, Load).
- With LOOPS=L≥1: End is entered at edge k+2+DWELL+(L·NUM_PAT−1)(DWELL+3).
- NUM_PAT=1: Next keeps PAT_ADR at 0; NXT_ADR still pulses.
- DWELL=1: Wait lasts one cycle.
- ABORT while in Wait at edge j: End at j. Exactly one LOAD_PAT pulse is issued per Load visit.

## Test plan
- Reset: assert RST mid-Wait → CLEAR=1, DISP=0, PAT_ADR=0, BUSY=0 immediately, with no clock edge needed; after release the block stays in Idle while RUN=0.
- Basic run, NUM_PAT=3, DWELL=4, LOOPS=1:
  - RUN at edge 0 → LOAD_PAT pulses at edges 1, 8 and 15 with PAT_ADR 0, 1, 2.
  - NXT_ADR pulses at edges 6 and 13.
  - End at edge 20: DONE=1, CLEAR=1, DISP=0, PAT_ADR=2.
- Looping, NUM_PAT=3, DWELL=4, LOOPS=2 → six LOAD_PAT pulses with PAT_ADR 0,1,2,0,1,2; End at edge 41.
- Infinite mode, LOOPS=0 → no DONE after 1000 cycles; PAT_ADR wraps from 2 to 0 repeatedly; BUSY stays 1.
- ABORT: ABORT during the second Wait → End on the next edge, DONE=1, PAT_ADR frozen at 1, no further LOAD_PAT; RUN toggling afterwards has no effect.
- Edge cases:
  - NUM_PAT=1, DWELL=1, LOOPS=1 → LOAD_PAT at edge 1, End at edge 3.
  - RUN held high throughout → exactly one pass, no restart from End.
